// File: rtl/frame_packer_pkg.sv
// Shared frame geometry and FSM encoding for the pre-processing front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_packer_pkg;

  // Image geometry also consumed by the IIG and skin address generators.
  localparam int IMG_WIDTH_DFLT  = 160;
  localparam int IMG_HEIGHT_DFLT = 120;
  localparam int CNT_W_DFLT      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/frame_packer.sv
// Packs horizontally adjacent RGB565 pixels into 32-bit words and frames each image.
// Latency: a word appears 1 clock after its odd-column pixel is accepted.
// Backpressure: none; the source streams freely and idle cycles simply hold state.
module frame_packer
  import frame_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DFLT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iFrame_start,
  input  logic        iPixel_valid,
  input  logic [15:0] iPixel,
  output logic        oRun_IIG,
  output logic        oOutput_ready,
  output logic [31:0] oData_out,
  output logic        oFrame_done,
  output logic        oFrame_err
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   row_q, row_d;
  logic [15:0]        low_q, low_d;
  logic [31:0]        data_q, data_d;
  logic               rdy_q, rdy_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               is_last;
  logic               take_last;

  // Next-state, pairing and counter logic; defaults hold state and drop pulses.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    low_d   = low_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    run_d   = iFrame_start;

    is_last   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    // The final pixel of a frame wins over a coincident restart so the last word still goes out.
    take_last = (state_q == ST_ACTIVE) && iPixel_valid && is_last;

    unique case (state_q)
      ST_ACTIVE: begin
        if (iFrame_start && !take_last) begin
          // Mid-frame restart: drop any pending half word; a same-cycle pixel is (0,0).
          err_d = 1'b1;
          row_d = '0;
          col_d = iPixel_valid ? CNT_W'(1) : '0;
          low_d = iPixel_valid ? iPixel : 16'h0000;
        end else if (iPixel_valid) begin
          if (col_q[0]) begin
            data_d = {iPixel, low_q};
            rdy_d  = 1'b1;
          end else begin
            low_d = iPixel;
          end
          if (is_last) begin
            col_d   = '0;
            row_d   = '0;
            done_d  = 1'b1;
            state_d = iFrame_start ? ST_ACTIVE : ST_DONE;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = iFrame_start ? ST_ACTIVE : ST_IDLE;
        if (iFrame_start) begin
          col_d = '0;
          row_d = '0;
          low_d = 16'h0000;
        end
      end
      default: begin
        if (iFrame_start) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          low_d   = 16'h0000;
        end
      end
    endcase
  end

  // State, counters and registered outputs; async reset returns everything to idle.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      low_q   <= 16'h0000;
      data_q  <= 32'h0000_0000;
      rdy_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      low_q   <= low_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oRun_IIG      = run_q;
  assign oOutput_ready = rdy_q;
  assign oData_out     = data_q;
  assign oFrame_done   = done_q;
  assign oFrame_err    = err_q;

endmodule
